store_packer: RTL and testbench
===============================

Name: store_packer

Overview:
- Write-side counterpart to the load/immediate extension path: narrows 32-bit register data into word-aligned memory writes.
- Takes a store request (byte address, 32-bit register data, size) and produces a word address, lane-shifted write data and a 4-bit byte enable.
- Sits between the MEM stage store logic and the data memory. A small FIFO decouples the two with valid/ready handshakes on both sides.
- Misaligned and reserved-size requests are rejected with an error pulse.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, at least 2.
- AW, 32, byte-address width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous clear of all queued entries.
- in_valid  input  1  store request present.
- in_ready  output  1  packer can accept a request this cycle.
- in_addr  input  AW  byte address.
- in_data  input  32  register data; low bits are significant for sb and sh.
- in_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- mem_valid  output  1  head entry valid.
- mem_ready  input  1  memory consumes the head entry this cycle.
- mem_addr  output  AW  word address, {in_addr[AW-1:2], 2'b00}.
- mem_wdata  output  32  lane-shifted data.
- mem_be  output  4  byte enables; bit i covers mem_wdata[8i+7:8i].
- err  output  1  one-cycle pulse: the previous request was rejected.

Behaviour:
- Reset (reset_n = 0 at a clock edge):
  - count = 0, pointers = 0.
  - mem_valid = 0, err = 0, in_ready = 1.
  - mem_addr, mem_wdata and mem_be read 0.
- Priority at each edge: reset > flush > normal operation.
- Flush:
  - Empties the FIFO (count = 0), clears err, and ignores the push attempted in that cycle.
  - in_ready during a flush cycle follows the pre-flush count.
- Accept: in_valid && in_ready at an edge. in_ready = (count < DEPTH). There is no combinational pass-through to in_ready when full.
- Pack rules (lane k = in_addr[1:0], h = in_addr[1]):
  - size 0: be = 1 << k; wdata = in_data[7:0] in lane k, other lanes 0.
  - size 1: requires in_addr[0] = 0. be = h ? 4'b1100 : 4'b0011; wdata = in_data[15:0] in the half selected by h, other half 0.
  - size 2: requires in_addr[1:0] = 0. be = 4'b1111; wdata = in_data.
  - size 3, or a failed alignment check: request is rejected.
- Rejected request:
  - Consumes the handshake; nothing is enqueued.
  - err = 1 in the next cycle only, then returns to 0.
- Good request: the packed entry is written at the tail. The earliest mem_valid is the following cycle, so the latency is 1 cycle.
- Output side:
  - mem_valid = (count != 0). mem_addr, mem_wdata and mem_be are driven from the head entry.
  - A pop occurs when mem_valid && mem_ready at an edge.
  - Outputs stay stable while mem_valid && !mem_ready.
  - When the FIFO is empty, the outputs read 0.
- Simultaneous push and pop:
  - When 0 < count < DEPTH, count is unchanged and both pointers advance.
  - When full, only the pop happens. in_ready was 0, so no push occurs.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never underflows or overflows.
- Ordering: strict FIFO; writes are never merged or reordered.

Decomposition:
- Shared package `mem_pkg`:
  - size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
  - a packed-entry struct {addr, wdata, be}.
  - function `be_of(size, lo2)`.
- Sub-module `sp_fifo`: a generic DEPTH x width synchronous FIFO with count, using the same reset and flush semantics.
- The top level keeps the combinational pack/check logic and the err register.

Test Plan:
- sb, in_addr = 0x0000_1003, in_data = 0x1234_56AB, mem_ready = 1 → next cycle mem_addr = 0x1000, mem_be = 4'b1000, mem_wdata = 0xAB00_0000, err = 0.
- sh, in_addr = 0x0000_2002, in_data = 0xFFFF_BEEF → mem_be = 4'b1100, mem_wdata = 0xBEEF_0000. Then sh at 0x2001 → no enqueue, err = 1 for exactly one cycle.
- mem_ready = 0; push sw at 0x10, 0x14, 0x18 back-to-back:
  - in_ready drops to 0 after the second accept; the third request is held.
  - After raising mem_ready, the outputs appear in order 0x10, 0x14, 0x18.
- Count = 1 with continuous push and pop for 8 cycles → count stays 1 and data order is preserved across pointer wrap.
- Two entries queued, assert flush alongside in_valid → next cycle mem_valid = 0, count = 0, the pushed entry is absent, in_ready = 1.
- Two entries queued, reset_n = 0 for one edge → mem_valid = 0, err = 0, outputs read 0. The following sw at 0x40 appears with mem_be = 4'b1111.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-write definitions for the store path.
// Provides the access-size encoding, the packed FIFO entry layout and the
// helpers that turn a (size, address low bits, register data) triple into
// byte enables, lane-shifted write data and an alignment verdict.
package mem_pkg;

    // Byte-address width carried inside a queued entry.
    localparam int unsigned MEM_AW = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } mem_entry_t;

    // Byte enables for an access of the given size at byte lane lo2.
    function automatic logic [3:0] be_of(input size_e size, input logic [1:0] lo2);
        logic [3:0] be;
        be = '0;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo2;
            SZ_HALF: be = lo2[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = '1;
            default: be = '0;
        endcase
        return be;
    endfunction

    // True when the access is a legal size and naturally aligned.
    function automatic logic aligned_ok(input size_e size, input logic [1:0] lo2);
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lo2[0];
            SZ_WORD: ok = (lo2 == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Places the significant low bits of the register into their lanes;
    // lanes not written are left zero.
    function automatic logic [31:0] wdata_of(input size_e size, input logic [1:0] lo2,
                                             input logic [31:0] data);
        logic [31:0] w;
        w = '0;
        case (size)
            SZ_BYTE: begin
                case (lo2)
                    2'd0:    w = {24'h0, data[7:0]};
                    2'd1:    w = {16'h0, data[7:0], 8'h0};
                    2'd2:    w = {8'h0, data[7:0], 16'h0};
                    default: w = {data[7:0], 24'h0};
                endcase
            end
            SZ_HALF: w = lo2[1] ? {data[15:0], 16'h0} : {16'h0, data[15:0]};
            SZ_WORD: w = data;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sp_fifo.sv
// Generic DEPTH x W synchronous FIFO with occupancy count.
// Ports:
//   clk, reset_n  - clock, synchronous active-low reset
//   flush         - synchronous clear of all entries (push in the same cycle ignored)
//   push, wdata   - write request and data (ignored when full)
//   pop           - consume head entry (ignored when empty)
//   rdata         - head entry, reads zero when empty
//   count         - number of occupied entries, 0..DEPTH
//   not_full      - count < DEPTH, from registered state only
module sp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 8,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          not_full
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign not_full = (count_q < CW'(DEPTH));
    assign count    = count_q;
    assign rdata    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        push_ok  = push && not_full && !flush;
        pop_ok   = pop && (count_q != '0) && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                // DEPTH is a power of two, so natural overflow wraps the pointer.
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: rdata is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/store_packer.sv
// Store packer: narrows 32-bit register data into word-aligned memory writes.
// Accepted requests are checked for size/alignment, lane-shifted, and queued
// in a small FIFO toward the data memory. Rejected requests pulse err.
// Ports:
//   clk, reset_n, flush          - clock, sync active-low reset, sync queue clear
//   in_valid/in_ready            - request handshake
//   in_addr, in_data, in_size    - byte address, register data, 0=b 1=h 2=w 3=rsvd
//   mem_valid/mem_ready          - memory-side handshake on the head entry
//   mem_addr, mem_wdata, mem_be  - word address, lane data, byte enables (0 when empty)
//   err                          - one-cycle pulse after a rejected request
// AW may not exceed mem_pkg::MEM_AW (the width of a queued address).
module store_packer
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [31:0]   in_data,
    input  logic [1:0]    in_size,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic          err
);

    localparam int unsigned EW = $bits(mem_entry_t);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    size_e         size;
    logic          accept;
    logic          good;
    logic          push;
    logic          pop;
    mem_entry_t    in_entry;
    mem_entry_t    head;
    logic [EW-1:0] head_raw;
    logic [CW-1:0] fifo_count;
    logic          err_q, err_d;

    always_comb begin
        size            = size_e'(in_size);
        good            = aligned_ok(size, in_addr[1:0]);
        accept          = in_valid && in_ready;
        push            = accept && good;
        in_entry        = '0;
        in_entry.addr   = MEM_AW'({in_addr[AW-1:2], 2'b00});
        in_entry.wdata  = wdata_of(size, in_addr[1:0], in_data);
        in_entry.be     = be_of(size, in_addr[1:0]);
        // Flush wipes a pending error together with the queue contents.
        err_d           = !flush && accept && !good;
    end

    assign mem_valid = (fifo_count != '0);
    assign pop       = mem_valid && mem_ready;
    assign head      = mem_entry_t'(head_raw);
    assign mem_addr  = AW'(head.addr);
    assign mem_wdata = head.wdata;
    assign mem_be    = head.be;
    assign err       = err_q;

    sp_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .push     (push),
        .wdata    (in_entry),
        .pop      (pop),
        .rdata    (head_raw),
        .count    (fifo_count),
        .not_full (in_ready)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_store_packer.sv
module tb_store_packer;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [1:0]  in_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    ent_t exp_q[$];
    logic m_err = 1'b0;

    store_packer #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_size   (in_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference packing from the arithmetic rules: lane k, half h.
    function automatic logic model_pack(input logic [31:0] a, input logic [31:0] d,
                                        input logic [1:0] s, output ent_t e);
        int unsigned k, h;
        logic ok;
        k = a % 4;
        h = (a / 2) % 2;
        e.addr = a & ~32'd3;
        e.be = 4'd0;
        e.wdata = 32'd0;
        ok = 1'b0;
        if (s == 2'd0) begin
            ok = 1'b1;
            e.be = 4'(1 << k);
            e.wdata = (d & 32'hFF) << (8 * k);
        end else if (s == 2'd1) begin
            ok = (a % 2 == 0);
            e.be = (h != 0) ? 4'd12 : 4'd3;
            e.wdata = (d & 32'hFFFF) << (16 * h);
        end else if (s == 2'd2) begin
            ok = (a % 4 == 0);
            e.be = 4'd15;
            e.wdata = d;
        end
        return ok;
    endfunction

    // Check all outputs against the model, then clock once and advance the model.
    task automatic step();
        ent_t h;
        ent_t e;
        logic ok;
        logic acc;
        if (exp_q.size() != 0) h = exp_q[0];
        else begin
            h.addr = '0; h.wdata = '0; h.be = '0;
        end
        check("mem_valid", mem_valid, exp_q.size() != 0);
        check("in_ready", in_ready, exp_q.size() < DEPTH);
        check("err", err, m_err);
        check("mem_addr", mem_addr, h.addr);
        check("mem_wdata", mem_wdata, h.wdata);
        check("mem_be", mem_be, h.be);
        check("count", dut.u_fifo.count_q, exp_q.size());
        @(posedge clk);
        if (!reset_n || flush) begin
            exp_q.delete();
            m_err = 1'b0;
        end else begin
            acc = in_valid && (exp_q.size() < DEPTH);
            ok = model_pack(in_addr, in_data, in_size, e);
            if (exp_q.size() != 0 && mem_ready) void'(exp_q.pop_front());
            if (acc && ok) exp_q.push_back(e);
            m_err = acc && !ok;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic rdy, input logic fl, input logic rn);
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        in_size   = s;
        mem_ready = rdy;
        flush     = fl;
        reset_n   = rn;
        step();
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 32'h0, 2'd0, rdy, 1'b0, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_addr = '0;
        in_data = '0; in_size = '0; mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_q.delete();
        m_err = 1'b0;

        // Reset state checked by the first step's pre-edge comparisons.
        idle(1'b1);

        // sb at 0x1003
        drive(1'b1, 32'h0000_1003, 32'h1234_56AB, 2'd0, 1'b1, 1'b0, 1'b1);
        check("tp_sb_addr", mem_addr, 32'h0000_1000);
        check("tp_sb_be", mem_be, 4'b1000);
        check("tp_sb_wdata", mem_wdata, 32'hAB00_0000);
        check("tp_sb_err", err, 1'b0);
        idle(1'b1);

        // sh at 0x2002, then misaligned sh at 0x2001
        drive(1'b1, 32'h0000_2002, 32'hFFFF_BEEF, 2'd1, 1'b1, 1'b0, 1'b1);
        check("tp_sh_be", mem_be, 4'b1100);
        check("tp_sh_wdata", mem_wdata, 32'hBEEF_0000);
        idle(1'b1);
        drive(1'b1, 32'h0000_2001, 32'hFFFF_BEEF, 2'd1, 1'b1, 1'b0, 1'b1);
        check("tp_mis_err", err, 1'b1);
        check("tp_mis_valid", mem_valid, 1'b0);
        idle(1'b1);
        check("tp_mis_err_clr", err, 1'b0);

        // Reserved size
        drive(1'b1, 32'h0000_3000, 32'h1, 2'd3, 1'b1, 1'b0, 1'b1);
        check("tp_rsvd_err", err, 1'b1);
        idle(1'b1);

        // Backpressure: three words with mem_ready low
        drive(1'b1, 32'h10, 32'hA0A0_0010, 2'd2, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h14, 32'hA0A0_0014, 2'd2, 1'b0, 1'b0, 1'b1);
        check("tp_full_ready", in_ready, 1'b0);
        drive(1'b1, 32'h18, 32'hA0A0_0018, 2'd2, 1'b0, 1'b0, 1'b1);
        check("tp_hold_head", mem_addr, 32'h10);
        drive(1'b1, 32'h18, 32'hA0A0_0018, 2'd2, 1'b1, 1'b0, 1'b1);
        check("tp_order_2", mem_addr, 32'h14);
        drive(1'b1, 32'h18, 32'hA0A0_0018, 2'd2, 1'b1, 1'b0, 1'b1);
        check("tp_order_3", mem_addr, 32'h18);
        idle(1'b1);
        idle(1'b1);

        // Steady push+pop at count 1 across pointer wrap
        drive(1'b1, 32'h100, 32'hC0DE_0100, 2'd2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h104 + 32'(4 * i), $urandom, 2'd2, 1'b1, 1'b0, 1'b1);
        end
        check("tp_steady_count", dut.u_fifo.count_q, 2'd1);
        check("tp_steady_head", mem_addr, 32'h120);
        idle(1'b1);

        // Flush with two queued and a push attempted
        drive(1'b1, 32'h200, 32'h1, 2'd2, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h204, 32'h2, 2'd2, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h208, 32'h3, 2'd2, 1'b0, 1'b1, 1'b1);
        check("tp_flush_valid", mem_valid, 1'b0);
        check("tp_flush_ready", in_ready, 1'b1);
        check("tp_flush_wdata", mem_wdata, 32'h0);
        idle(1'b1);

        // Reset with two queued, then sw at 0x40
        drive(1'b1, 32'h300, 32'h1, 2'd2, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h304, 32'h2, 2'd2, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("tp_rst_valid", mem_valid, 1'b0);
        check("tp_rst_err", err, 1'b0);
        check("tp_rst_addr", mem_addr, 32'h0);
        check("tp_rst_be", mem_be, 4'h0);
        drive(1'b1, 32'h40, 32'h5555_AAAA, 2'd2, 1'b1, 1'b0, 1'b1);
        check("tp_sw40_be", mem_be, 4'b1111);
        check("tp_sw40_addr", mem_addr, 32'h40);
        idle(1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            drive(($urandom % 4) != 0, $urandom, $urandom, 2'($urandom % 4),
                  ($urandom % 3) != 0, ($urandom % 25) == 0, ($urandom % 60) != 0);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
